fila_resolucao_desvio: RTL and testbench
========================================

# fila_resolucao_desvio

In-order branch resolution queue between fetch and execute. It records every conditional branch predicted by the gshare predictor, together with the table index used, and compares the oldest entry against the outcome from execute. It emits a one-cycle update pulse back to the predictor and, on a misprediction, flushes younger entries and redirects fetch.

## Interface
- PROFUNDIDADE, 4, queue entries (power of 2, ≥2)
- LARGURA_PC, 32, PC/target width
- LARGURA_IDX, 10, predictor table index width
- LARGURA_OCUP, derived, $clog2(PROFUNDIDADE)+1 (localparam, not overridable)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- prev_valido  in  1  fetch pushes a predicted branch this cycle
- prev_tomado  in  1  predicted direction (1 = taken)
- prev_pc  in  LARGURA_PC  branch PC
- prev_alvo  in  LARGURA_PC  predicted target
- prev_idx  in  LARGURA_IDX  predictor index used for this prediction
- prev_pronto  out  1  push accepted this cycle
- res_valido  in  1  execute resolves the oldest outstanding branch
- res_tomado  in  1  actual direction
- res_alvo  in  LARGURA_PC  actual taken target
- atualiza_valido  out  1  registered one-cycle update pulse to predictor
- atualiza_idx  out  LARGURA_IDX  index to train
- atualiza_tomado  out  1  actual direction to train
- atualiza_acerto  out  1  1 = prediction correct (hit), 0 = miss
- redireciona  out  1  registered one-cycle fetch redirect pulse
- redireciona_pc  out  LARGURA_PC  redirect address
- ocupacao  out  LARGURA_OCUP  entries currently held
- erro_res  out  1  sticky: resolve seen with queue empty

## Operation
- Circular FIFO; write/read pointers wrap modulo PROFUNDIDADE. Each entry holds {tomado, pc, alvo, idx}.
- FSM states NORMAL, RECUPERA. Reset → NORMAL.
- prev_pronto = (estado == NORMAL) && (ocupacao < PROFUNDIDADE). This is combinational from registered state only. Push occurs iff prev_valido && prev_pronto. Pushes while prev_pronto = 0 are dropped silently.
- Resolve with ocupacao > 0: compare against head entry.
  - Miss iff res_tomado != head.tomado, or (res_tomado && res_alvo != head.alvo).
  - A not-taken branch ignores target mismatch.
- Hit: pop head; atualiza_valido = 1, atualiza_acerto = 1, atualiza_idx = head.idx, atualiza_tomado = res_tomado.
- Miss: same update pulse with atualiza_acerto = 0. Flush the entire queue (pointers and ocupacao → 0). Assert redireciona with redireciona_pc = res_tomado ? res_alvo : head.pc + 4, modulo 2^LARGURA_PC. FSM → RECUPERA.
- RECUPERA lasts exactly one cycle (prev_pronto = 0), then returns to NORMAL.
- Push and hit-resolve in the same cycle: both happen, so ocupacao is unchanged. This is allowed even when full? No: when full, prev_pronto = 0, so the push is dropped.
- Push and miss-resolve in the same cycle: the push is younger and is discarded. Queue ends empty.
- Resolve with queue empty: no pop, no pulses. erro_res is set and stays 1 until reset. A simultaneous push still proceeds.
- res_valido while in RECUPERA: treated per the rules above; the queue is empty, so erro_res is set.

## Timing
- Reset values: prev_pronto 1 after reset deasserts. atualiza_valido, atualiza_acerto, atualiza_tomado, redireciona, erro_res all 0. atualiza_idx, redireciona_pc, and ocupacao all 0. Queue empty.
- Asynchronous reset mid-operation discards all entries and pending pulses immediately.
- Update/redirect latency: outputs are registered one cycle after the res_valido edge. Pulses are exactly one cycle wide unless a resolve occurs on every cycle.
- ocupacao reflects pushes/pops on the cycle after the edge.
- Back-to-back resolves every cycle are supported. Throughput is 1 push + 1 resolve per cycle.
- After a miss: cycle N+1 has redireciona = 1 and prev_pronto = 0. From cycle N+2, prev_pronto = 1.

## Test plan
- Reset → fill: push 4 branches (pc 0x100, 0x104, 0x108, 0x10C). Expect ocupacao = 4 and prev_pronto = 0. A 5th push is dropped and ocupacao stays 4.
- Hit: head {tomado = 1, alvo = 0x200, idx = 5}; resolve res_tomado = 1, res_alvo = 0x200. Next cycle: atualiza_valido = 1, acerto = 1, idx = 5, tomado = 1, redireciona = 0, and ocupacao decrements.
- Direction miss: head {pc = 0x100, tomado = 1}, 3 entries queued; resolve res_tomado = 0. Next cycle: acerto = 0, redireciona = 1, redireciona_pc = 0x104, ocupacao = 0, prev_pronto = 0. The cycle after: prev_pronto = 1.
- Target miss plus simultaneous push: head {tomado = 1, alvo = 0x200}; resolve res_tomado = 1, res_alvo = 0x300 with prev_valido = 1. Expect redireciona_pc = 0x300 and ocupacao = 0 (push discarded).
- Empty resolve: res_valido with queue empty and prev_valido = 1. Expect erro_res = 1 (sticky), no atualiza pulse, ocupacao = 1.
- Wrap-around plus async reset: 10 push/hit cycles with ocupacao held at 2 and indices checked in order. Assert rst mid-cycle: all outputs at reset values immediately.

Source files
------------

// File: rtl/fila_resolucao_desvio_if.sv
// Fetch/execute-side signal bundle for the branch resolution queue.
// Prediction pushes, resolve inputs, and predictor-update/redirect outputs travel here.
interface fila_resolucao_desvio_if #(
    parameter int PROFUNDIDADE = 4,
    parameter int LARGURA_PC   = 32,
    parameter int LARGURA_IDX  = 10
);
    localparam int LARGURA_OCUP = $clog2(PROFUNDIDADE) + 1;

    logic                    prev_valido;
    logic                    prev_tomado;
    logic [LARGURA_PC-1:0]   prev_pc;
    logic [LARGURA_PC-1:0]   prev_alvo;
    logic [LARGURA_IDX-1:0]  prev_idx;
    logic                    prev_pronto;

    logic                    res_valido;
    logic                    res_tomado;
    logic [LARGURA_PC-1:0]   res_alvo;

    logic                    atualiza_valido;
    logic [LARGURA_IDX-1:0]  atualiza_idx;
    logic                    atualiza_tomado;
    logic                    atualiza_acerto;
    logic                    redireciona;
    logic [LARGURA_PC-1:0]   redireciona_pc;
    logic [LARGURA_OCUP-1:0] ocupacao;
    logic                    erro_res;

    modport master (
        output prev_valido, prev_tomado, prev_pc, prev_alvo, prev_idx,
        output res_valido, res_tomado, res_alvo,
        input  prev_pronto, atualiza_valido, atualiza_idx, atualiza_tomado,
        input  atualiza_acerto, redireciona, redireciona_pc, ocupacao, erro_res
    );

    modport slave (
        input  prev_valido, prev_tomado, prev_pc, prev_alvo, prev_idx,
        input  res_valido, res_tomado, res_alvo,
        output prev_pronto, atualiza_valido, atualiza_idx, atualiza_tomado,
        output atualiza_acerto, redireciona, redireciona_pc, ocupacao, erro_res
    );
endinterface

// File: rtl/fila_resolucao_desvio.sv
// In-order branch resolution queue: checks the oldest predicted branch against execute's
// outcome, trains the predictor, and on a miss flushes the queue and redirects fetch.
module fila_resolucao_desvio #(
    parameter int PROFUNDIDADE = 4,
    parameter int LARGURA_PC   = 32,
    parameter int LARGURA_IDX  = 10
) (
    input logic                    clk,
    input logic                    rst,
    fila_resolucao_desvio_if.slave bus
);
    localparam int LARGURA_PTR  = $clog2(PROFUNDIDADE);
    localparam int LARGURA_OCUP = LARGURA_PTR + 1;
    localparam logic [LARGURA_OCUP-1:0] OCUP_CHEIA = LARGURA_OCUP'(PROFUNDIDADE);

    typedef enum logic {NORMAL, RECUPERA} estado_t;

    typedef struct packed {
        logic                   tomado;
        logic [LARGURA_PC-1:0]  pc;
        logic [LARGURA_PC-1:0]  alvo;
        logic [LARGURA_IDX-1:0] idx;
    } entrada_t;

    estado_t estado, estado_prox;

    entrada_t                fila [PROFUNDIDADE];
    entrada_t                cabeca;
    logic [LARGURA_PTR-1:0]  ptr_escrita, ptr_leitura;
    logic [LARGURA_OCUP-1:0] ocupacao;

    logic prev_pronto, empurra, resolve, erro_agora, erro, acerto;

    logic                   atualiza_valido, atualiza_tomado, atualiza_acerto;
    logic [LARGURA_IDX-1:0] atualiza_idx;
    logic                   redireciona;
    logic [LARGURA_PC-1:0]  redireciona_pc;
    logic                   erro_res;

    assign cabeca      = fila[ptr_leitura];
    assign prev_pronto = (estado == NORMAL) && (ocupacao < OCUP_CHEIA);
    assign empurra     = bus.prev_valido && prev_pronto;
    assign resolve     = bus.res_valido && (ocupacao != '0);
    assign erro_agora  = bus.res_valido && (ocupacao == '0);

    // A not-taken branch is correct on direction alone; its predicted target is irrelevant.
    always_comb begin
        erro   = 1'b0;
        acerto = 1'b0;
        if (resolve) begin
            erro   = (bus.res_tomado != cabeca.tomado) ||
                     (bus.res_tomado && (bus.res_alvo != cabeca.alvo));
            acerto = !erro;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) estado <= NORMAL;
        else     estado <= estado_prox;
    end

    // RECUPERA is a single stall cycle that blocks pushes while fetch follows the redirect.
    always_comb begin
        estado_prox = NORMAL;
        case (estado)
            NORMAL:   estado_prox = erro ? RECUPERA : NORMAL;
            RECUPERA: estado_prox = NORMAL;
            default:  estado_prox = NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (empurra) begin
            fila[ptr_escrita] <= '{tomado: bus.prev_tomado, pc: bus.prev_pc,
                                   alvo: bus.prev_alvo, idx: bus.prev_idx};
        end
    end

    // A miss wipes everything, including any push arriving in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_escrita <= '0;
            ptr_leitura <= '0;
            ocupacao    <= '0;
        end else if (erro) begin
            ptr_escrita <= '0;
            ptr_leitura <= '0;
            ocupacao    <= '0;
        end else begin
            if (empurra) ptr_escrita <= ptr_escrita + 1'b1;
            if (acerto)  ptr_leitura <= ptr_leitura + 1'b1;
            if (empurra && !acerto)      ocupacao <= ocupacao + 1'b1;
            else if (acerto && !empurra) ocupacao <= ocupacao - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            atualiza_valido <= 1'b0;
            atualiza_idx    <= '0;
            atualiza_tomado <= 1'b0;
            atualiza_acerto <= 1'b0;
            redireciona     <= 1'b0;
            redireciona_pc  <= '0;
            erro_res        <= 1'b0;
        end else begin
            atualiza_valido <= resolve;
            redireciona     <= erro;
            if (resolve) begin
                atualiza_idx    <= cabeca.idx;
                atualiza_tomado <= bus.res_tomado;
                atualiza_acerto <= acerto;
            end
            if (erro) begin
                redireciona_pc <= bus.res_tomado ? bus.res_alvo
                                                 : cabeca.pc + LARGURA_PC'(4);
            end
            if (erro_agora) erro_res <= 1'b1;
        end
    end

    assign bus.prev_pronto     = prev_pronto;
    assign bus.atualiza_valido = atualiza_valido;
    assign bus.atualiza_idx    = atualiza_idx;
    assign bus.atualiza_tomado = atualiza_tomado;
    assign bus.atualiza_acerto = atualiza_acerto;
    assign bus.redireciona     = redireciona;
    assign bus.redireciona_pc  = redireciona_pc;
    assign bus.ocupacao        = ocupacao;
    assign bus.erro_res        = erro_res;
endmodule

// File: tb/tb_fila_resolucao_desvio.sv
// Directed self-checking bench for fila_resolucao_desvio with hand-computed expectations.
module tb_fila_resolucao_desvio;
    logic clk;
    logic rst;
    int   total;
    int   passed;

    fila_resolucao_desvio_if #(.PROFUNDIDADE(4), .LARGURA_PC(32), .LARGURA_IDX(10)) bus ();

    fila_resolucao_desvio #(.PROFUNDIDADE(4), .LARGURA_PC(32), .LARGURA_IDX(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observado,
                               input logic [31:0] esperado);
        total++;
        if (observado !== esperado)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observado, esperado);
        else
            passed++;
    endtask

    task automatic applyStimulus(input logic pv, input logic pt, input logic [31:0] ppc,
                                 input logic [31:0] palvo, input logic [9:0] pidx,
                                 input logic rv, input logic rt, input logic [31:0] ralvo);
        bus.prev_valido = pv;
        bus.prev_tomado = pt;
        bus.prev_pc     = ppc;
        bus.prev_alvo   = palvo;
        bus.prev_idx    = pidx;
        bus.res_valido  = rv;
        bus.res_tomado  = rt;
        bus.res_alvo    = ralvo;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 10'd0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        idleCycle();
        idleCycle();
        rst = 1'b0;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst    = 1'b1;
        doReset();

        checkOutput("rst_pronto",   32'(bus.prev_pronto),     32'd1);
        checkOutput("rst_ocup",     32'(bus.ocupacao),        32'd0);
        checkOutput("rst_atu_val",  32'(bus.atualiza_valido), 32'd0);
        checkOutput("rst_atu_idx",  32'(bus.atualiza_idx),    32'd0);
        checkOutput("rst_redir",    32'(bus.redireciona),     32'd0);
        checkOutput("rst_redir_pc", bus.redireciona_pc,       32'd0);
        checkOutput("rst_erro",     32'(bus.erro_res),        32'd0);

        // Fill to capacity, then try one extra push
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h100 + 32'(4 * i), 32'h200, 10'(5 + i),
                          1'b0, 1'b0, 32'h0);
            checkOutput("fill_ocup", 32'(bus.ocupacao), 32'(i + 1));
        end
        checkOutput("full_pronto", 32'(bus.prev_pronto), 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h110, 32'h200, 10'd99, 1'b0, 1'b0, 32'h0);
        checkOutput("drop_ocup", 32'(bus.ocupacao), 32'd4);

        // Hit on head {tomado=1, alvo=0x200, idx=5}
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 10'd0, 1'b1, 1'b1, 32'h200);
        checkOutput("hit_val",    32'(bus.atualiza_valido), 32'd1);
        checkOutput("hit_acerto", 32'(bus.atualiza_acerto), 32'd1);
        checkOutput("hit_idx",    32'(bus.atualiza_idx),    32'd5);
        checkOutput("hit_tomado", 32'(bus.atualiza_tomado), 32'd1);
        checkOutput("hit_redir",  32'(bus.redireciona),     32'd0);
        checkOutput("hit_ocup",   32'(bus.ocupacao),        32'd3);
        idleCycle();
        checkOutput("hit_pulse_end", 32'(bus.atualiza_valido), 32'd0);

        // Direction miss with three entries queued
        doReset();
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b1, 32'h100 + 32'(4 * i), 32'h200, 10'(1 + i),
                          1'b0, 1'b0, 32'h0);
        checkOutput("dmiss_pre_ocup", 32'(bus.ocupacao), 32'd3);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 10'd0, 1'b1, 1'b0, 32'h0);
        checkOutput("dmiss_val",      32'(bus.atualiza_valido), 32'd1);
        checkOutput("dmiss_acerto",   32'(bus.atualiza_acerto), 32'd0);
        checkOutput("dmiss_idx",      32'(bus.atualiza_idx),    32'd1);
        checkOutput("dmiss_tomado",   32'(bus.atualiza_tomado), 32'd0);
        checkOutput("dmiss_redir",    32'(bus.redireciona),     32'd1);
        checkOutput("dmiss_redir_pc", bus.redireciona_pc,       32'h104);
        checkOutput("dmiss_ocup",     32'(bus.ocupacao),        32'd0);
        checkOutput("dmiss_pronto",   32'(bus.prev_pronto),     32'd0);
        idleCycle();
        checkOutput("recov_pronto",   32'(bus.prev_pronto),     32'd1);
        checkOutput("recov_redir",    32'(bus.redireciona),     32'd0);

        // Target miss with a simultaneous push that must be discarded
        applyStimulus(1'b1, 1'b1, 32'h140, 32'h200, 10'd9, 1'b0, 1'b0, 32'h0);
        checkOutput("tmiss_pre_ocup", 32'(bus.ocupacao), 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h150, 32'h500, 10'd10, 1'b1, 1'b1, 32'h300);
        checkOutput("tmiss_redir",    32'(bus.redireciona),     32'd1);
        checkOutput("tmiss_redir_pc", bus.redireciona_pc,       32'h300);
        checkOutput("tmiss_acerto",   32'(bus.atualiza_acerto), 32'd0);
        checkOutput("tmiss_idx",      32'(bus.atualiza_idx),    32'd9);
        checkOutput("tmiss_ocup",     32'(bus.ocupacao),        32'd0);
        checkOutput("tmiss_erro",     32'(bus.erro_res),        32'd0);
        idleCycle();

        // Resolve against an empty queue while a push proceeds
        applyStimulus(1'b1, 1'b0, 32'h160, 32'h0, 10'd12, 1'b1, 1'b0, 32'h0);
        checkOutput("empty_erro",    32'(bus.erro_res),        32'd1);
        checkOutput("empty_atu_val", 32'(bus.atualiza_valido), 32'd0);
        checkOutput("empty_ocup",    32'(bus.ocupacao),        32'd1);
        idleCycle();
        checkOutput("erro_sticky",   32'(bus.erro_res),        32'd1);

        // Steady push+hit through pointer wrap; not-taken ignores target mismatch
        doReset();
        applyStimulus(1'b1, 1'b0, 32'h300, 32'h400, 10'd20, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h304, 32'h404, 10'd21, 1'b0, 1'b0, 32'h0);
        checkOutput("wrap_pre_ocup", 32'(bus.ocupacao), 32'd2);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 1'b0, 32'h308 + 32'(4 * k), 32'h408 + 32'(4 * k),
                          10'(22 + k), 1'b1, 1'b0, 32'hDEAD);
            checkOutput("wrap_val",    32'(bus.atualiza_valido), 32'd1);
            checkOutput("wrap_acerto", 32'(bus.atualiza_acerto), 32'd1);
            checkOutput("wrap_idx",    32'(bus.atualiza_idx),    32'(20 + k));
            checkOutput("wrap_ocup",   32'(bus.ocupacao),        32'd2);
            checkOutput("wrap_redir",  32'(bus.redireciona),     32'd0);
        end

        // Asynchronous reset between clock edges
        bus.prev_valido = 1'b0;
        bus.res_valido  = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_ocup",    32'(bus.ocupacao),        32'd0);
        checkOutput("arst_atu_val", 32'(bus.atualiza_valido), 32'd0);
        checkOutput("arst_atu_idx", 32'(bus.atualiza_idx),    32'd0);
        checkOutput("arst_acerto",  32'(bus.atualiza_acerto), 32'd0);
        checkOutput("arst_pronto",  32'(bus.prev_pronto),     32'd1);
        checkOutput("arst_erro",    32'(bus.erro_res),        32'd0);
        idleCycle();
        rst = 1'b0;
        idleCycle();
        checkOutput("post_arst_ocup", 32'(bus.ocupacao), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
